// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding and
// the word-alignment mask applied to the access address.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/Register.sv
// Generic write-enabled register with asynchronous active-high reset.
module Register #(
    parameter int                   BIT_WIDTH   = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrt_en,
    input  logic [BIT_WIDTH-1:0] data_in,
    output logic [BIT_WIDTH-1:0] data_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       data_out <= RESET_VALUE;
        else if (wrt_en) data_out <= data_in;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues load/store over a req/ack handshake, stalls
// EX/MEM while the access is outstanding and owns the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int TIMEOUT             = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     EX_op,
    input  logic [3:0]                     EX_func,
    input  logic [DBITS-1:0]               EX_regData2,
    input  logic [DBITS-1:0]               EX_intermediateResult,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rs2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
    input  logic                           EX_ME_mux_sel,
    input  logic                           EX_wrReg,
    input  logic                           EX_wrMem,
    output logic                           stall,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [DBITS-1:0]               mem_addr,
    output logic [DBITS-1:0]               mem_wdata,
    input  logic [DBITS-1:0]               mem_rdata,
    input  logic                           mem_ack,
    output logic [DBITS-1:0]               MEM_result,
    output logic [REG_INDEX_BIT_WIDTH-1:0] MEM_rd,
    output logic                           MEM_wrReg,
    output logic                           mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t                         state, state_nxt;
    logic [CNT_W-1:0]               cnt, cnt_nxt;
    logic                           req_nxt, we_nxt, err_nxt, stall_c;
    logic [DBITS-1:0]               addr_nxt, wdata_nxt, result_nxt, sdata;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd_nxt;
    logic                           wrreg_nxt;
    logic                           access, aligned;
    logic                           unused_ex;

    assign unused_ex = ^{EX_op, EX_func};
    assign access    = EX_wrMem | EX_ME_mux_sel;
    assign aligned   = (EX_intermediateResult[1:0] & ALIGN_MASK) == 2'b00;
    // Forward the value currently leaving MEM/WB if the store reads that register
    assign sdata     = (MEM_wrReg && MEM_rd == EX_rs2) ? MEM_result : EX_regData2;
    assign stall     = stall_c & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_nxt    = mem_req;
        we_nxt     = mem_we;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;
        err_nxt    = mem_err;
        result_nxt = EX_intermediateResult;
        rd_nxt     = EX_rd;
        wrreg_nxt  = 1'b0;
        stall_c    = 1'b0;
        case (state)
            IDLE: begin
                if (!access) begin
                    wrreg_nxt = EX_wrReg;
                end else if (aligned) begin
                    stall_c   = 1'b1;
                    req_nxt   = 1'b1;
                    we_nxt    = EX_wrMem;
                    addr_nxt  = EX_intermediateResult;
                    wdata_nxt = sdata;
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            REQ: begin
                stall_c    = 1'b1;
                cnt_nxt    = cnt + 1'b1;
                result_nxt = MEM_result;
                if (mem_ack) begin
                    req_nxt    = 1'b0;
                    result_nxt = mem_we ? mem_addr : mem_rdata;
                    wrreg_nxt  = EX_wrReg;
                    state_nxt  = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    req_nxt    = 1'b0;
                    err_nxt    = 1'b1;
                    result_nxt = '0;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                // Held instruction already retired; insert a bubble behind it
                result_nxt = MEM_result;
                rd_nxt     = MEM_rd;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    Register #(.BIT_WIDTH(DBITS)) u_result_reg (
        .clk(clk), .reset(reset), .wrt_en(1'b1), .data_in(result_nxt), .data_out(MEM_result)
    );

    Register #(.BIT_WIDTH(REG_INDEX_BIT_WIDTH)) u_rd_reg (
        .clk(clk), .reset(reset), .wrt_en(1'b1), .data_in(rd_nxt), .data_out(MEM_rd)
    );

    Register #(.BIT_WIDTH(1)) u_wrreg_reg (
        .clk(clk), .reset(reset), .wrt_en(1'b1), .data_in(wrreg_nxt), .data_out(MEM_wrReg)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized + directed bench for mem_stage against a transaction-level model
// of the writeback register, forwarding rule and sticky error flag.
module tb_mem_stage;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  EX_op, EX_func;
    logic [31:0] EX_regData2, EX_intermediateResult;
    logic [3:0]  EX_rs2, EX_rd;
    logic        EX_ME_mux_sel, EX_wrReg, EX_wrMem;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, MEM_result;
    logic [3:0]  MEM_rd;
    logic        MEM_wrReg, mem_err;

    int n_cmp = 0;
    int n_err = 0;

    // model of what MEM/WB and the error flag should hold
    logic [31:0] m_res;
    logic [3:0]  m_rd;
    logic        m_wr;
    logic        m_err;

    always #5 clk = ~clk;

    mem_stage #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .EX_op(EX_op), .EX_func(EX_func), .EX_regData2(EX_regData2),
        .EX_intermediateResult(EX_intermediateResult), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
        .EX_ME_mux_sel(EX_ME_mux_sel), .EX_wrReg(EX_wrReg), .EX_wrMem(EX_wrMem),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .MEM_result(MEM_result), .MEM_rd(MEM_rd), .MEM_wrReg(MEM_wrReg), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Present one instruction (entered just after a posedge) and follow it to
    // retirement. ack_n = REQ cycle on which memory acks; 0 = never.
    task automatic do_instr(input logic [31:0] rd2, input logic [31:0] ir, input logic [3:0] rs2,
                            input logic [3:0] rd, input logic ld, input logic wrr, input logic st,
                            input int ack_n, input logic [31:0] rdata_v);
        logic [31:0] sdata;
        logic        acked, timed, store;
        int          k;
        EX_op = 4'($urandom); EX_func = 4'($urandom);
        EX_regData2 = rd2; EX_intermediateResult = ir; EX_rs2 = rs2; EX_rd = rd;
        EX_ME_mux_sel = ld; EX_wrReg = wrr; EX_wrMem = st;
        store = st;
        sdata = (m_wr && m_rd == rs2) ? m_res : rd2;
        if (!(ld | st)) begin
            mem_ack = 1'($urandom);          // stray ack must be ignored
            @(negedge clk); chk("alu_stall", stall, 0);
            @(posedge clk); #1; mem_ack = 1'b0;
            m_res = ir; m_rd = rd; m_wr = wrr;
            chk("alu_result", MEM_result, m_res); chk("alu_rd", MEM_rd, m_rd);
            chk("alu_wr", MEM_wrReg, m_wr);       chk("alu_req", mem_req, 0);
            chk("alu_err", mem_err, m_err);
        end else if (ir[1:0] != 2'b00) begin
            @(negedge clk); chk("mis_stall", stall, 0);
            @(posedge clk); #1;
            m_wr = 1'b0; m_err = 1'b1;
            chk("mis_req", mem_req, 0); chk("mis_err", mem_err, 1); chk("mis_wr", MEM_wrReg, 0);
        end else begin
            @(negedge clk); chk("iss_stall", stall, 1); chk("iss_req", mem_req, 0);
            acked = 1'b0; timed = 1'b0; k = 0;
            while (!acked && !timed) begin
                @(posedge clk); #1; mem_ack = 1'b0;
                k++;
                chk("req_req", mem_req, 1);      chk("req_we", mem_we, store);
                chk("req_addr", mem_addr, ir);   chk("req_wdata", mem_wdata, sdata);
                chk("req_stall", stall, 1);      chk("req_bubble", MEM_wrReg, 0);
                if (ack_n != 0 && k == ack_n) begin
                    mem_ack = 1'b1; mem_rdata = rdata_v; acked = 1'b1;
                end else if (k == TIMEOUT) begin
                    timed = 1'b1;
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'($urandom);              // ack during DONE must be ignored
            mem_rdata = $urandom;
            if (timed) m_err = 1'b1;
            chk("done_stall", stall, 0); chk("done_req", mem_req, 0);
            chk("done_result", MEM_result, timed ? 32'h0 : (store ? ir : rdata_v));
            chk("done_rd", MEM_rd, rd);
            chk("done_wr", MEM_wrReg, timed ? 1'b0 : wrr);
            chk("done_err", mem_err, m_err);
            @(posedge clk); #1; mem_ack = 1'b0;
            m_wr = 1'b0;
            chk("post_bubble", MEM_wrReg, 0);
            chk("post_req", mem_req, 0);
        end
    endtask

    task automatic clear_inputs();
        EX_op = '0; EX_func = '0; EX_regData2 = '0; EX_intermediateResult = '0;
        EX_rs2 = '0; EX_rd = '0; EX_ME_mux_sel = 0; EX_wrReg = 0; EX_wrMem = 0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        clear_inputs();
        reset = 1'b1;
        m_res = '0; m_rd = '0; m_wr = 1'b0; m_err = 1'b0;
        #1;
        chk("rst_stall", stall, 0);     chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);       chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0); chk("rst_result", MEM_result, 0);
        chk("rst_rd", MEM_rd, 0);       chk("rst_wr", MEM_wrReg, 0);
        chk("rst_err", mem_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // directed cases
        do_instr(32'h0, 32'h1234, 4'd0, 4'd3, 0, 1, 0, 0, 32'h0);
        do_instr(32'h0, 32'h40, 4'd1, 4'd5, 1, 1, 0, 3, 32'hCAFEF00D);
        do_instr(32'h0, 32'hAA55, 4'd0, 4'd7, 0, 1, 0, 0, 32'h0);
        do_instr(32'h0, 32'h80, 4'd7, 4'd0, 0, 0, 1, 2, 32'h0);
        do_instr(32'h0, 32'h4C, 4'd2, 4'd4, 1, 1, 1, 1, 32'h1111);   // load+store -> store
        do_instr(32'h0, 32'h42, 4'd0, 4'd6, 1, 1, 0, 1, 32'h0);
        do_instr(32'h0, 32'h44, 4'd0, 4'd9, 1, 1, 0, 0, 32'h0);      // timeout

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            do_instr($urandom, a,
                     ($urandom_range(0, 1) == 1) ? m_rd : 4'($urandom), 4'($urandom),
                     kind == 1 || kind == 3, 1'($urandom), kind >= 2,
                     int'($urandom_range(1, 5)), $urandom);
        end

        // reset while a load is waiting for its ack
        EX_intermediateResult = 32'h100; EX_ME_mux_sel = 1'b1; EX_wrMem = 1'b0;
        EX_wrReg = 1'b1; EX_rd = 4'd2;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req", mem_req, 0);  chk("mid_rst_stall", stall, 0);
        chk("mid_rst_wr", MEM_wrReg, 0); chk("mid_rst_err", mem_err, 0);
        clear_inputs();
        m_res = '0; m_rd = '0; m_wr = 1'b0; m_err = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        do_instr(32'h0, 32'h5678, 4'd0, 4'd11, 0, 1, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
